tof_uart_reporter: RTL and testbench

- Measures the time between a "signal sent" event (`signalSendt` rising edge) and a trigger event (`trigg` rising edge), in clock cycles.
- Reports the 32-bit result over a UART TX line as 4 bytes, MSB first, 8N1.
- Drives three status LEDs.
- Top-level FPGA block; the TX line feeds a standard 8N1 UART receiver running at the same CLKS_PER_BIT.

---
 rtl/tof_uart_reporter.sv | 167 ++++++++++++++++
 tb/tb_tof_uart_reporter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tof_uart_reporter.sv
// Time-of-flight meter: counts clk cycles from the signalSendt rise to the trigg rise,
// then reports the 32-bit count over an 8N1 UART, MSB byte first.
module tof_uart_reporter #(
  parameter int CLKS_PER_BIT = 87,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trigg,
  input  logic signalSendt,
  output logic TX,
  output logic reset_led,
  output logic trigg_led,
  output logic signal_led
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    TX_START,
    TX_DATA,
    TX_STOP
  } state_t;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n, cnt_inc;
  logic [CNT_W-1:0]  result_q, result_n;
  logic [BAUD_W-1:0] baud_q, baud_n;
  logic [2:0]        bit_q, bit_n;
  logic [1:0]        byte_q, byte_n;
  logic              tled_q, tled_n;
  logic              tx_q, tx_n;
  logic              sled_q;
  logic              rled_q;
  logic [7:0]        tx_byte;

  // [1:0] form the synchronizer, [2] is the previous synchronized value
  logic [2:0] trig_sh, send_sh;
  logic       trig_p, start_p;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      trig_sh <= '0;
      send_sh <= '0;
    end else begin
      trig_sh <= {trig_sh[1:0], trigg};
      send_sh <= {send_sh[1:0], signalSendt};
    end
  end

  assign trig_p  = trig_sh[1] & ~trig_sh[2];
  assign start_p = send_sh[1] & ~send_sh[2];
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      tled_q   <= 1'b0;
      tx_q     <= 1'b1;
      sled_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      result_q <= result_n;
      baud_q   <= baud_n;
      bit_q    <= bit_n;
      byte_q   <= byte_n;
      tled_q   <= tled_n;
      tx_q     <= tx_n;
      sled_q   <= (state_n == MEASURE);
    end
  end

  always_ff @(posedge clk) begin
    rled_q <= ~reset_n;
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    result_n = result_q;
    baud_n   = baud_q;
    bit_n    = bit_q;
    byte_n   = byte_q;
    tled_n   = tled_q;
    tx_n     = 1'b1;
    tx_byte  = '0;

    case (state_q)
      IDLE: begin
        if (start_p) begin
          cnt_n   = '0;
          state_n = MEASURE;
        end
      end
      MEASURE: begin
        // the cycle carrying the trigger pulse is itself one more period
        if (trig_p) begin
          result_n = cnt_inc;
          tled_n   = ~tled_q;
          byte_n   = '0;
          baud_n   = '0;
          state_n  = TX_START;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      TX_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = TX_DATA;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_n = '0;
          if (bit_q == 3'd7) begin
            state_n = TX_STOP;
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_n = '0;
          if (byte_q == 2'd3) begin
            state_n = IDLE;
          end else begin
            byte_n  = byte_q + 2'd1;
            state_n = TX_START;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // line level is registered from the next state so TX never glitches
    tx_byte = result_n[{~byte_n, 3'b000} +: 8];
    case (state_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = tx_byte[bit_n];
      default:  tx_n = 1'b1;
    endcase
  end

  assign TX         = tx_q;
  assign reset_led  = rled_q;
  assign trigg_led  = tled_q;
  assign signal_led = sled_q;

endmodule

// File: tb/tb_tof_uart_reporter.sv
// Directed bench for tof_uart_reporter: a bench-side UART receiver decodes TX and
// compares each byte with the report computed from the raw edge timing.
module tb_tof_uart_reporter;

  localparam int CPB  = 87;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic trigg = 1'b0;
  logic signalSendt = 1'b0;
  logic TX, reset_led, trigg_led, signal_led;

  tof_uart_reporter #(.CLKS_PER_BIT(CPB), .CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trigg      (trigg),
    .signalSendt(signalSendt),
    .TX         (TX),
    .reset_led  (reset_led),
    .trigg_led  (trigg_led),
    .signal_led (signal_led)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic rst_q = 1'b0;
  logic started = 1'b0;
  logic tled_exp = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  logic rx_busy = 1'b0;
  logic tx_prev = 1'b1;
  int rx_cnt = 0;
  logic [7:0] rx_byte = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_q <= reset_n;
    started <= 1'b1;
  end

  // Per-cycle checks: reset behaviour, and an idle line whenever no report is pending.
  always @(negedge clk) begin
    if (started) begin
      chk("reset_led", {31'd0, reset_led}, {31'd0, ~rst_q});
      if (!rst_q) begin
        chk("tx_in_reset", {31'd0, TX}, 32'd1);
        chk("signal_led_in_reset", {31'd0, signal_led}, 32'd0);
        chk("trigg_led_in_reset", {31'd0, trigg_led}, 32'd0);
      end else if (exp_q.size() == 0 && !rx_busy) begin
        chk("tx_idle", {31'd0, TX}, 32'd1);
      end
    end
  end

  // 8N1 receiver model sampling mid-bit
  always @(negedge clk) begin
    if (!rst_q) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (TX === 1'b0 && tx_prev === 1'b1) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == HALF) begin
        chk("rx_start_bit", {31'd0, TX}, 32'd0);
      end else if (rx_cnt == HALF + 9 * CPB) begin
        chk("rx_stop_bit", {31'd0, TX}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("rx_unexpected_byte", {24'd0, rx_byte}, 32'hFFFF_FFFF);
        end else begin
          chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
        end
        rx_log.push_back(rx_byte);
        rx_busy = 1'b0;
      end else if (rx_cnt > HALF && (rx_cnt - HALF) % CPB == 0) begin
        rx_byte[(rx_cnt - HALF) / CPB - 1] = TX;
      end
    end
    tx_prev = TX;
  end

  // One measurement episode with double pulses on both inputs; d = cycles between raw rises.
  task automatic episode(input int d);
    int ts, tt;
    longint unsigned delta;
    logic [31:0] val;
    @(negedge clk); signalSendt = 1'b1; ts = cyc;
    repeat (2) @(negedge clk); signalSendt = 1'b0;
    repeat (2) @(negedge clk); signalSendt = 1'b1;
    repeat (2) @(negedge clk); signalSendt = 1'b0;
    repeat (d - 6) @(negedge clk);
    chk("signal_led_measuring", {31'd0, signal_led}, 32'd1);
    trigg = 1'b1; tt = cyc;
    delta = longint'(tt - ts);
    val = (delta > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : delta[31:0];
    exp_q.push_back(val[31:24]);
    exp_q.push_back(val[23:16]);
    exp_q.push_back(val[15:8]);
    exp_q.push_back(val[7:0]);
    tled_exp = ~tled_exp;
    repeat (2) @(negedge clk); trigg = 1'b0;
    repeat (2) @(negedge clk); trigg = 1'b1;
    repeat (2) @(negedge clk); trigg = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || rx_busy) && k < budget) begin
      @(negedge clk); k++;
    end
    chk("report_done_in_time", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);
    chk("signal_led_after_report", {31'd0, signal_led}, 32'd0);
    chk("trigg_led_model", {31'd0, trigg_led}, {31'd0, tled_exp});
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (rx_log.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    chk("bytes_arrived_in_time", 32'(rx_log.size()), 32'(n));
  endtask

  task automatic quiet_window(input string name, input int cycles);
    int base, lows, sled;
    base = rx_log.size();
    lows = 0;
    sled = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
      if (signal_led !== 1'b0) sled++;
    end
    chk({name, "_no_bytes"}, 32'(rx_log.size()), 32'(base));
    chk({name, "_tx_low_cycles"}, 32'(lows), 32'd0);
    chk({name, "_signal_led_cycles"}, 32'(sled), 32'd0);
  endtask

  task automatic run_width(input logic lvl, output int w);
    w = 0;
    while (TX === lvl && w < 2000) begin
      w++; @(negedge clk);
    end
  endtask

  initial begin
    int base, k, w;
    logic [7:0] b;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", {31'd0, TX}, 32'd1);
    chk("reset_reset_led", {31'd0, reset_led}, 32'd1);
    chk("reset_signal_led", {31'd0, signal_led}, 32'd0);
    chk("reset_trigg_led", {31'd0, trigg_led}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("release_reset_led", {31'd0, reset_led}, 32'd0);
    quiet_window("after_reset", 200);

    // basic measurement: 5160 ns = 258 cycles
    base = rx_log.size();
    episode(258);
    wait_done(50 * CPB);
    chk("ep1_byte0", {24'd0, rx_log[base]}, 32'h00);
    chk("ep1_byte1", {24'd0, rx_log[base+1]}, 32'h00);
    chk("ep1_byte2", {24'd0, rx_log[base+2]}, 32'h01);
    chk("ep1_byte3", {24'd0, rx_log[base+3]}, 32'h02);
    chk("ep1_trigg_led", {31'd0, trigg_led}, 32'd1);

    repeat (20000) @(negedge clk);

    // repeat episode, with bit timing on the 0x01 byte (start 0, bit0 1, bits1..7 0)
    base = rx_log.size();
    episode(258);
    wait_log(base + 2, 30 * CPB);
    k = 0;
    while (TX !== 1'b0 && k < 400) begin
      @(negedge clk); k++;
    end
    run_width(1'b0, w);
    chk("start_bit_width", 32'(w), 32'(CPB));
    run_width(1'b1, w);
    chk("data_bit0_width", 32'(w), 32'(CPB));
    run_width(1'b0, w);
    chk("data_bits1to7_width", 32'(w), 32'(7 * CPB));
    run_width(1'b1, w);
    chk("stop_bit_width_ok", {31'd0, (w == CPB || w == CPB + 1)}, 32'd1);
    wait_done(50 * CPB);
    b = rx_log[base+2];
    chk("ep2_byte2", {24'd0, b}, 32'h01);
    b = rx_log[base+3];
    chk("ep2_byte3", {24'd0, b}, 32'h02);
    chk("ep2_trigg_led", {31'd0, trigg_led}, 32'd0);

    // trigger pulse while idle
    @(negedge clk); trigg = 1'b1;
    repeat (3) @(negedge clk); trigg = 1'b0;
    quiet_window("idle_trigg", 45 * CPB);
    chk("idle_trigg_led", {31'd0, trigg_led}, {31'd0, tled_exp});

    // start pulse during SEND must neither disturb the frame nor arm a new measurement
    base = rx_log.size();
    episode(100);
    wait_log(base + 1, 30 * CPB);
    signalSendt = 1'b1;
    repeat (3) @(negedge clk); signalSendt = 1'b0;
    wait_done(50 * CPB);
    chk("send_start_byte3", {24'd0, rx_log[base+3]}, 32'h64);
    quiet_window("after_send_start", 300);
    trigg = 1'b1;
    repeat (3) @(negedge clk); trigg = 1'b0;
    quiet_window("no_rearm", 45 * CPB);

    // reset during the second byte's data bits
    base = rx_log.size();
    episode(300);
    wait_log(base + 1, 30 * CPB);
    repeat (200) @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    tled_exp = 1'b0;
    @(posedge clk); #1;
    chk("midframe_reset_tx", {31'd0, TX}, 32'd1);
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    quiet_window("after_abort", 45 * CPB);
    chk("abort_dropped_bytes", 32'(rx_log.size()), 32'(base + 1));

    // recovery: 1000 = 0x000003E8
    base = rx_log.size();
    episode(1000);
    wait_done(50 * CPB);
    chk("rec_byte0", {24'd0, rx_log[base]}, 32'h00);
    chk("rec_byte1", {24'd0, rx_log[base+1]}, 32'h00);
    chk("rec_byte2", {24'd0, rx_log[base+2]}, 32'h03);
    chk("rec_byte3", {24'd0, rx_log[base+3]}, 32'hE8);
    chk("rec_trigg_led", {31'd0, trigg_led}, 32'd1);

    repeat (50) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
